// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer slice: FSM state encodings,
// synchronizer depth and small constant helpers for parameter sizing.
`timescale 1ns/1ps
package reset_sequencer_pkg;

    // FSM state encodings shared by every reset sequencer instance
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_SEQ  = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_e;

    // Number of flops in the async-assert / sync-release synchronizer
    localparam int SYNC_DEPTH = 2;

    // Larger of two integers, used to size the shared gap/hold counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Index width for n entries, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-release reset synchronizer.
// The output drops the moment rstn_async falls and rises only after
// DEPTH clean clock edges with rstn_async high.
`timescale 1ns/1ps
module reset_sync
    import reset_sequencer_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic clk,
    input  logic rstn_async,
    output logic rstn_sync
);

    logic [DEPTH-1:0] sync_r;

    // Shift ones in after release; clear the whole chain immediately on assert
    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            sync_r <= {DEPTH{1'b0}};
        end else begin
            sync_r <= {sync_r[DEPTH-2:0], 1'b1};
        end
    end

    assign rstn_sync = sync_r[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_DOM downstream reset domains one at a time, GAP_CYC cycles
// apart, after the board reset or after a software reset request.
// Outputs assert asynchronously with rstn and deassert synchronously.
`timescale 1ns/1ps
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_DOM    = 4,
    parameter int GAP_CYC  = 8,
    parameter int HOLD_CYC = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sw_rst_req,
    output logic [N_DOM-1:0] dom_rstn,
    output logic             rst_done,
    output logic             busy
);

    localparam int CW = $clog2(max_int(GAP_CYC, HOLD_CYC) + 1);
    localparam int IW = idx_width(N_DOM);

    // Releasing happens on the edge where the counter has already spent
    // GAP_CYC-1 cycles in SEQ, so each domain is GAP_CYC edges after the last.
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DOM - 1);

    logic             rstn_s;
    seq_state_e       state_r;
    logic [CW-1:0]    cnt_r;
    logic [IW-1:0]    idx_r;
    logic [N_DOM-1:0] dom_rstn_r;
    logic             rst_done_r;
    logic             busy_r;
    logic             por_skip_r;
    logic [N_DOM-1:0] release_mask_s;

    reset_sync #(
        .DEPTH      (SYNC_DEPTH)
    ) u_reset_sync (
        .clk        (clk),
        .rstn_async (rstn),
        .rstn_sync  (rstn_s)
    );

    assign release_mask_s = N_DOM'(1) << idx_r;

    // Sequencing FSM with registered domain resets, done and busy flags
    always_ff @(posedge clk or negedge rstn_s) begin
        if (!rstn_s) begin
            state_r    <= ST_HOLD;
            cnt_r      <= {CW{1'b0}};
            idx_r      <= {IW{1'b0}};
            dom_rstn_r <= {N_DOM{1'b0}};
            rst_done_r <= 1'b0;
            busy_r     <= 1'b1;
            // After a board reset the hold phase is skipped entirely
            por_skip_r <= 1'b1;
        end else if (sw_rst_req) begin
            state_r    <= ST_HOLD;
            cnt_r      <= {CW{1'b0}};
            idx_r      <= {IW{1'b0}};
            dom_rstn_r <= {N_DOM{1'b0}};
            rst_done_r <= 1'b0;
            busy_r     <= 1'b1;
            por_skip_r <= 1'b0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    dom_rstn_r <= {N_DOM{1'b0}};
                    rst_done_r <= 1'b0;
                    busy_r     <= 1'b1;
                    if (por_skip_r || (cnt_r == HOLD_LAST)) begin
                        state_r    <= ST_SEQ;
                        cnt_r      <= {CW{1'b0}};
                        idx_r      <= {IW{1'b0}};
                        por_skip_r <= 1'b0;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CW'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_SEQ: begin
                    rst_done_r <= 1'b0;
                    busy_r     <= 1'b1;
                    if (cnt_r == GAP_LAST) begin
                        dom_rstn_r <= dom_rstn_r | release_mask_s;
                        cnt_r      <= {CW{1'b0}};
                        if (idx_r == IDX_LAST) begin
                            state_r    <= ST_RUN;
                            idx_r      <= {IW{1'b0}};
                            rst_done_r <= 1'b1;
                            busy_r     <= 1'b0;
                        end else begin
                            idx_r <= idx_r + IW'(1);
                        end
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CW'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_RUN: begin
                    dom_rstn_r <= {N_DOM{1'b1}};
                    rst_done_r <= 1'b1;
                    busy_r     <= 1'b0;
                    cnt_r      <= {CW{1'b0}};
                end
                default: begin
                    // Unreachable encoding: fall back to a full, safe re-sequence
                    state_r    <= ST_HOLD;
                    cnt_r      <= {CW{1'b0}};
                    idx_r      <= {IW{1'b0}};
                    dom_rstn_r <= {N_DOM{1'b0}};
                    rst_done_r <= 1'b0;
                    busy_r     <= 1'b1;
                    por_skip_r <= 1'b0;
                end
            endcase
        end
    end

    assign dom_rstn = dom_rstn_r;
    assign rst_done = rst_done_r;
    assign busy     = busy_r;

endmodule
